// File: rtl/bus_buffered_register_pkg.sv
// bus_buffered_register_pkg: shared CPU data-bus constants
package bus_buffered_register_pkg;
  localparam int DATA_W = 8;
endpackage

// File: rtl/bus_buffered_register_tristate_driver.sv
// tristate_driver: drives y with d while en is high, otherwise floats y to all-Z
// ports: en (output enable), d (data to drive), y (tri-state bus output)
module tristate_driver
  import bus_buffered_register_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output tri   [WIDTH-1:0] y
);
  assign y = en ? d : {WIDTH{1'bz}};
endmodule

// File: rtl/bus_buffered_register.sv
// bus_buffered_register: loadable register that drives a shared tri-state data bus
// ports: clk, rst (async, active high), ld (load enable), en (bus output enable),
//        in (load data), out (tri-state bus driver), q (always-driven stored value)
module bus_buffered_register
  import bus_buffered_register_pkg::*;
#(
  parameter int               WIDTH       = DATA_W,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  output tri   [WIDTH-1:0] out,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= RESET_VALUE;
    else if (ld) q <= in;
  // the bus is driven from the stored value only, so a load never flows through combinationally
  tristate_driver #(.WIDTH(WIDTH)) u_drv (.en(en), .d(q), .y(out));
endmodule

// File: tb/tb_bus_buffered_register.sv
// tb_bus_buffered_register: two registers sharing one 8-bit bus, table vectors plus corner sequences
module tb_bus_buffered_register;
  logic clk = 1'b0;
  logic rst, ld_a, ld_b, en_a, en_b;
  logic [7:0] in_a, in_b, q_a, q_b;
  tri   [7:0] bus;
  int checks = 0;
  int failures = 0;
  bit four_state;
  logic [7:0] ma, mb;
  typedef struct {
    logic       ld_a;
    logic [7:0] in_a;
    logic       ld_b;
    logic [7:0] in_b;
    logic       en_a;
    logic       en_b;
    logic [7:0] exp_qa;
    logic [7:0] exp_qb;
  } vec_t;
  typedef struct {
    logic [7:0] qa;
    logic [7:0] qb;
  } exp_t;
  vec_t vecs[8];
  exp_t sb[$];

  bus_buffered_register #(.WIDTH(8), .RESET_VALUE(8'h00)) ua (
    .clk(clk), .rst(rst), .ld(ld_a), .en(en_a), .in(in_a), .out(bus), .q(q_a)
  );
  bus_buffered_register #(.WIDTH(8), .RESET_VALUE(8'h00)) ub (
    .clk(clk), .rst(rst), .ld(ld_b), .en(en_b), .in(in_b), .out(bus), .q(q_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected bus: one enabled driver gives its value, none gives Z, two give X on differing bits.
  // A two-state simulator cannot show X/Z, so there only the bits both drivers agree on are compared
  // and a released bus reads as zero.
  task automatic chk_bus(input string name);
    logic [7:0] val, mask, exp;
    mask = (en_a && en_b) ? ~(ma ^ mb) : 8'hff;
    val = en_a ? ma : en_b ? mb : 8'h00;
    checks++;
    if (four_state) begin
      exp = (en_a || en_b) ? val : 8'hzz;
      for (int i = 0; i < 8; i++) if (!mask[i]) exp[i] = 1'bx;
      if (bus !== exp) begin
        failures++;
        $display("FAIL %s: bus got %h expected %h", name, bus, exp);
      end
    end else if ((bus & mask) !== (val & mask)) begin
      failures++;
      $display("FAIL %s: bus got %h expected %h on mask %h", name, bus, val, mask);
    end
  endtask

  initial begin
    logic xp;
    exp_t e;
    xp = 1'bx;
    four_state = $isunknown(xp);
    vecs[0] = '{1'b1, 8'hAA, 1'b1, 8'hBB, 1'b0, 1'b0, 8'hAA, 8'hBB};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'hAA, 8'hBB};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'hAA, 8'hBB};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'hAA, 8'hBB};
    vecs[4] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'hAA, 8'hBB};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'hAA, 8'hBB};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'hAA, 8'hBB};
    vecs[7] = '{1'b0, 8'h11, 1'b0, 8'h22, 1'b1, 1'b0, 8'hAA, 8'hBB};
    ma = 8'h00;
    mb = 8'h00;
    rst = 1'b1; en_a = 1'b1; en_b = 1'b0;
    ld_a = 1'b1; in_a = 8'h77; ld_b = 1'b0; in_b = 8'h00;
    #1;
    chk("reset q_a", q_a, 8'h00);
    chk("reset q_b", q_b, 8'h00);
    chk_bus("reset bus");
    @(posedge clk); #1;
    chk("ld during reset ignored", q_a, 8'h00);
    @(negedge clk);
    rst = 1'b0; ld_a = 1'b0; en_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ld_a = vecs[i].ld_a; in_a = vecs[i].in_a;
      ld_b = vecs[i].ld_b; in_b = vecs[i].in_b;
      en_a = vecs[i].en_a; en_b = vecs[i].en_b;
      sb.push_back('{vecs[i].exp_qa, vecs[i].exp_qb});
      @(posedge clk);
      if (vecs[i].ld_a) ma = vecs[i].in_a;
      if (vecs[i].ld_b) mb = vecs[i].in_b;
      #1;
      e = sb.pop_front();
      chk($sformatf("vec%0d q_a", i), q_a, e.qa);
      chk($sformatf("vec%0d q_b", i), q_b, e.qb);
      chk_bus($sformatf("vec%0d bus", i));
    end
    @(negedge clk);
    en_a = 1'b1; en_b = 1'b0; ld_a = 1'b1; ld_b = 1'b0; in_a = 8'h5C;
    #1 chk_bus("load-enabled before edge");
    #1 in_a = 8'hC5;
    #1 chk_bus("load-enabled in toggle no flow");
    in_a = 8'h5C;
    @(posedge clk);
    ma = 8'h5C;
    #1;
    chk_bus("load-enabled after edge");
    chk("load-enabled q_a", q_a, 8'h5C);
    ld_a = 1'b0; in_a = 8'h99;
    #2 chk_bus("in toggle ld=0 bus");
    @(negedge clk) in_a = 8'h0F;
    @(posedge clk); #1;
    chk("in toggle ld=0 q_a", q_a, 8'h5C);
    #1 rst = 1'b1;
    #1;
    ma = 8'h00;
    mb = 8'h00;
    chk_bus("async reset bus");
    chk("async reset q_a", q_a, 8'h00);
    chk("async reset q_b", q_b, 8'h00);
    #1 rst = 1'b0;
    @(negedge clk);
    ld_a = 1'b1; in_a = 8'h3F;
    @(posedge clk);
    ma = 8'h3F;
    #1;
    chk("load after reset q_a", q_a, 8'h3F);
    chk_bus("load after reset bus");
    ld_a = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
